// File: rtl/sine_burst_tx_pkg.sv
// rtl/sine_burst_tx_pkg.sv - shared sine coefficients, state encoding and sample scaling
package sine_burst_tx_pkg;

   localparam int SINE_LEN  = 20;
   localparam int AMP_UNITY = 128;

   // One full period of the reference, also used by the receive-side correlator.
   localparam logic signed [7:0] SINE_T [SINE_LEN] = '{
      8'sd0,    8'sd39,   8'sd75,   8'sd103,  8'sd121,
      8'sd127,  8'sd121,  8'sd103,  8'sd75,   8'sd39,
      8'sd0,   -8'sd39,  -8'sd75,  -8'sd103, -8'sd121,
     -8'sd127, -8'sd121, -8'sd103, -8'sd75,  -8'sd39
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Scale a coefficient by amp/128 with floor rounding, clamp to +-127, then
   // optionally invert; clamping before inversion keeps -128 unreachable.
   function automatic logic signed [7:0] scale_sample(input logic signed [7:0] coef,
                                                      input logic        [7:0] amp,
                                                      input logic              neg);
      logic signed [16:0] prod;
      logic signed [9:0]  shf;
      logic signed [7:0]  sat;
      prod = coef * $signed({1'b0, amp});
      shf  = prod[16:7];
      if (shf > 10'sd127) begin
         sat = 8'sd127;
      end else if (shf < -10'sd127) begin
         sat = -8'sd127;
      end else begin
         sat = shf[7:0];
      end
      return neg ? -sat : sat;
   endfunction

endpackage

// File: rtl/sine_burst_tx_rom.sv
// rtl/sine_burst_tx_rom.sv - slot index to signed sine coefficient lookup
module sine_rom
   import sine_burst_tx_pkg::*;
(
   input  logic        [4:0] idx_i,
   output logic signed [7:0] coef_o
);

   // Table lookup; indices past the last slot read as zero.
   always_comb begin
      coef_o = '0;
      if (idx_i < 5'(SINE_LEN)) begin
         coef_o = SINE_T[idx_i];
      end
   end

endmodule

// File: rtl/sine_burst_tx.sv
// rtl/sine_burst_tx.sv - burst generator of scaled, phase-selectable 20-slot sine samples
module sine_burst_tx
   import sine_burst_tx_pkg::*;
#(
   parameter int DIV    = 1,
   parameter int NPER_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     sym,
   input  logic        [7:0]        amp,
   input  logic        [NPER_W-1:0] nper,
   output logic signed [7:0]        sample,
   output logic        [4:0]        tim,
   output logic                     valid,
   output logic                     busy,
   output logic                     done
);

   localparam logic [7:0]        DIV_LAST = 8'(DIV - 1);
   localparam logic [4:0]        TIM_LAST = 5'(SINE_LEN - 1);
   localparam logic [NPER_W-1:0] NPER_ONE = NPER_W'(1);

   state_e                    state_q, state_d;
   logic        [7:0]         hold_q, hold_d;
   logic        [NPER_W-1:0]  per_q, per_d;
   logic                      sym_q, sym_d;
   logic        [7:0]         amp_q, amp_d;
   logic        [NPER_W-1:0]  nper_q, nper_d;
   logic signed [7:0]         sample_q, sample_d;
   logic        [4:0]         tim_q, tim_d;
   logic                      valid_q, valid_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      load_smp, clear_smp;
   logic signed [7:0]         rom_coef;

   // The ROM is addressed with the upcoming slot so the sample lands with its tim.
   sine_rom u_rom (
      .idx_i  (tim_d),
      .coef_o (rom_coef)
   );

   // Next-state logic: stop wins over everything, then per-state sequencing.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      per_d     = per_q;
      sym_d     = sym_q;
      amp_d     = amp_q;
      nper_d    = nper_q;
      tim_d     = tim_q;
      valid_d   = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      load_smp  = 1'b0;
      clear_smp = 1'b0;
      if (stop) begin
         state_d   = ST_IDLE;
         hold_d    = '0;
         per_d     = '0;
         tim_d     = '0;
         busy_d    = 1'b0;
         clear_smp = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && (nper != '0)) begin
                  state_d  = ST_RUN;
                  sym_d    = sym;
                  amp_d    = amp;
                  nper_d   = nper;
                  hold_d   = '0;
                  per_d    = '0;
                  tim_d    = '0;
                  valid_d  = 1'b1;
                  busy_d   = 1'b1;
                  load_smp = 1'b1;
               end
            end
            ST_RUN: begin
               if (hold_q == DIV_LAST) begin
                  hold_d = '0;
                  if (tim_q == TIM_LAST) begin
                     if ((per_q + NPER_ONE) == nper_q) begin
                        state_d   = ST_DONE;
                        per_d     = '0;
                        tim_d     = '0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        clear_smp = 1'b1;
                     end else begin
                        per_d    = per_q + NPER_ONE;
                        tim_d    = '0;
                        valid_d  = 1'b1;
                        load_smp = 1'b1;
                     end
                  end else begin
                     tim_d    = tim_q + 5'd1;
                     valid_d  = 1'b1;
                     load_smp = 1'b1;
                  end
               end else begin
                  hold_d = hold_q + 8'd1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
            default: begin
               state_d   = ST_IDLE;
               busy_d    = 1'b0;
               tim_d     = '0;
               clear_smp = 1'b1;
            end
         endcase
      end
   end

   // Sample path: scale the new slot's coefficient with the parameters in force next cycle.
   always_comb begin
      sample_d = sample_q;
      if (clear_smp) begin
         sample_d = '0;
      end else if (load_smp) begin
         sample_d = scale_sample(rom_coef, amp_d, sym_d);
      end
   end

   // State, counters, latched parameters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         hold_q   <= '0;
         per_q    <= '0;
         sym_q    <= 1'b0;
         amp_q    <= '0;
         nper_q   <= '0;
         sample_q <= '0;
         tim_q    <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         per_q    <= per_d;
         sym_q    <= sym_d;
         amp_q    <= amp_d;
         nper_q   <= nper_d;
         sample_q <= sample_d;
         tim_q    <= tim_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign sample = sample_q;
   assign tim    = tim_q;
   assign valid  = valid_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule
